peripheral_uart_rx: RTL

- UART receiver peripheral for the J1 I/O bus; the receive-side counterpart of the existing transmit-only UART peripheral.
- Deserialises 8N1 frames from an external line into a small receive FIFO.
- The CPU reads bytes and status through the standard cs/addr/rd/wr register interface.
- Sits behind a dedicated chip-select in the SoC address decoder, like every other peripheral.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/peripheral_uart_rx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the J1 UART receiver: register offsets, STATUS bit
// positions and the receive FSM state encoding.
package uart_rx_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h2;
  localparam logic [3:0] REG_CTRL   = 4'h4;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_PARITY_ERR = 4;
  localparam int ST_COUNT_LSB  = 5;

  localparam int CTRL_CLEAR = 0;
  localparam int CTRL_FLUSH = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with push/pop/flush; DEPTH must be a power of two
// so the pointers wrap naturally. Flush overrides any push or pop.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // a pop frees the slot the simultaneous push needs, so full only blocks a lone push
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_uart_rx.sv
// UART receiver peripheral for the J1 I/O bus: 8N1 deserialiser into a small FIFO.
// Optional even parity is compiled in with UART_RX_PARITY_EN.
//
//   state    | meaning
//   S_IDLE   | line idle, waiting for a falling edge
//   S_START  | timing half a bit to re-check the start bit
//   S_DATA   | sampling 8 data bits, LSB first, one per DIV cycles
//   S_PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
//   S_STOP   | sampling the stop bit; push or flag frame error
module peripheral_uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        uart_rx,
  output logic        rx_irq
);

  localparam int          DIV      = CLK_FREQ / BAUD;
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] DIV_HALF = 16'(DIV / 2);
  localparam int          CW       = $clog2(FIFO_DEPTH + 1);

  rx_state_t     state;
  rx_state_t     state_nxt;
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tick_half;
  logic          tick_full;
  logic          cnt_clr;
  logic          shift_en;
  logic          push;
  logic          frame_evt;
  logic          overrun_evt;
  logic          overrun;
  logic          frame_err;
  logic          parity_err;
  logic          rd_pop;
  logic          ctrl_wr;
  logic          clr;
  logic          flush;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [15:0]   status;
  logic          ctrl_unused;

`ifdef UART_RX_PARITY_EN
  logic parity_evt;
  logic par_bad;
`endif

  assign ctrl_unused = ^d_in[15:2];

  // preset high so reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign tick_half = (bit_cnt == DIV_HALF);
  assign tick_full = (bit_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (rx_prev && !rx_s2) state_nxt = S_START;
      S_START: if (tick_half) state_nxt = rx_s2 ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (tick_full && bit_idx == 3'd7) state_nxt = S_PARITY;
      S_PARITY: if (tick_full) state_nxt = S_STOP;
`else
      S_DATA:  if (tick_full && bit_idx == 3'd7) state_nxt = S_STOP;
`endif
      S_STOP:  if (tick_full) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    push      = 1'b0;
    frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_evt = 1'b0;
`endif
    case (state)
      S_IDLE:  cnt_clr = 1'b1;
      S_START: cnt_clr = tick_half;
      S_DATA: begin
        cnt_clr  = tick_full;
        shift_en = tick_full;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        cnt_clr    = tick_full;
        parity_evt = tick_full & (rx_s2 != ^shift);
      end
      S_STOP: begin
        cnt_clr   = tick_full;
        push      = tick_full & rx_s2 & ~par_bad;
        frame_evt = tick_full & ~rx_s2;
      end
`else
      S_STOP: begin
        cnt_clr   = tick_full;
        push      = tick_full & rx_s2;
        frame_evt = tick_full & ~rx_s2;
      end
`endif
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      bit_cnt <= cnt_clr ? 16'd0 : bit_cnt + 16'd1;
      if (state == S_IDLE) bit_idx <= '0;
      else if (shift_en)   bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift <= {rx_s2, shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) par_bad <= 1'b0;
    else if (parity_evt)        par_bad <= 1'b1;
  end
`endif

  assign rd_pop  = cs & rd & (addr == REG_DATA);
  assign ctrl_wr = cs & wr & (addr == REG_CTRL);
  assign clr     = ctrl_wr & d_in[CTRL_CLEAR];
  assign flush   = ctrl_wr & d_in[CTRL_FLUSH];

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift),
    .pop   (rd_pop),
    .flush (flush),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign overrun_evt = push & full & ~rd_pop;

  // a new error event in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= overrun_evt | (overrun & ~clr);
      frame_err <= frame_evt | (frame_err & ~clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= parity_evt | (parity_err & ~clr);
  end
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    status                   = '0;
    status[ST_NOT_EMPTY]     = ~empty;
    status[ST_FULL]          = full;
    status[ST_OVERRUN]       = overrun;
    status[ST_FRAME_ERR]     = frame_err;
    status[ST_PARITY_ERR]    = parity_err;
    status[ST_COUNT_LSB+:5]  = 5'(count);
  end

  always_comb begin
    d_out = 16'h0000;
    if (cs && !rst) begin
      case (addr)
        REG_DATA:   d_out = {8'h00, empty ? 8'h00 : head};
        REG_STATUS: d_out = status;
        default:    d_out = 16'h0000;
      endcase
    end
  end

  assign rx_irq = ~empty | overrun | frame_err | parity_err;

endmodule
